prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 256, SHALL set the instruction-memory capacity in 32-bit words.
REQ-002 Clocking SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_valid  input  1  a byte is presented on rx_data.
REQ-006 rx_data  input  8  program stream byte.
REQ-007 rx_ready  output  1  loader accepts a byte this cycle; a byte is transferred when rx_valid and rx_ready are both high.
REQ-008 imem_we  output  1  one-cycle write strobe to instruction memory.
REQ-009 imem_addr  output  32  byte address of the write, word aligned (word index x 4, matching pc).
REQ-010 imem_wdata  output  32  instruction word to write.
REQ-011 core_reset  output  1  held high to keep the core in reset; drives the core reset input.
REQ-012 load_done  output  1  image loaded and checksum matched.
REQ-013 load_error  output  1  image rejected.

Function
REQ-014 The stream format SHALL be: count low byte, count high byte (N = 16-bit word count), then N words of 4 bytes each, little-endian, then 1 checksum byte.
REQ-015 The state machine SHALL have states CNT_LO, CNT_HI, DATA, CSUM, DONE and ERROR.
REQ-016 rx_ready SHALL be 1 in CNT_LO, CNT_HI, DATA and CSUM, and SHALL be 0 in DONE, in ERROR, and in any cycle where reset is high.
REQ-017 CNT_LO SHALL go to CNT_HI on an accepted byte.
REQ-018 CNT_HI, on an accepted byte, SHALL:
- go to ERROR if N > IMEM_WORDS;
- go to CSUM if N = 0;
- otherwise go to DATA.
REQ-019 In DATA, bytes SHALL be assembled little-endian: byte 0 into bits [7:0], byte 3 into bits [31:24].
REQ-020 The cycle after the 4th byte of word k is accepted, imem_we SHALL be 1 for exactly one cycle, with imem_addr = 4k and imem_wdata = the assembled word.
REQ-021 On acceptance of the last byte of word N-1, DATA SHALL go to CSUM.
REQ-022 The checksum SHALL be the 8-bit sum modulo 256 of all data bytes; count bytes are excluded and the sum starts at 0.
REQ-023 CSUM, on an accepted byte, SHALL go to DONE if the byte equals the running sum, otherwise to ERROR.
REQ-024 DONE SHALL hold load_done = 1 and core_reset = 0 from the cycle after checksum acceptance until reset.
REQ-025 ERROR SHALL hold load_error = 1 and core_reset = 1 until reset.
REQ-026 Outside DONE, core_reset SHALL be 1; core_reset SHALL never deassert before the final imem write has completed.
REQ-027 Bytes presented while rx_ready = 0 SHALL be ignored.
REQ-028 A gap in rx_valid SHALL stall progress with no timeout and no change of state.
REQ-029 The word index SHALL count 0..N-1 without wrap; N = IMEM_WORDS is legal and fills the memory exactly.
REQ-030 Memory words at or above index N SHALL not be written.
REQ-031 The loader SHALL never assert imem_we outside DATA-to-CSUM operation.

Reset
REQ-032 While reset is high, on each rising edge the loader SHALL enter CNT_LO and clear the byte count, word index and checksum to 0.
REQ-033 While reset is high, outputs SHALL be: imem_we = 0, imem_addr = 0, imem_wdata = 0, load_done = 0, load_error = 0, core_reset = 1, rx_ready = 0.
REQ-034 Reset mid-load SHALL discard any partially assembled word and restart the protocol; words already written SHALL remain in memory.
REQ-035 Reset while in DONE SHALL re-assert core_reset on the next edge.

Verification
REQ-036 The bench SHALL cover: stream 02 00, 13 00 00 00, 93 00 10 00, checksum B6 -> writes 0x00000013 at 0 and 0x00100093 at 4, then load_done = 1 and core_reset = 0 the following cycle.
REQ-037 The bench SHALL cover: same stream with checksum B7 -> both writes occur, then load_error = 1, core_reset stays 1, and rx_ready = 0.
REQ-038 The bench SHALL cover: count 01 01 (N = 257 > 256) -> ERROR after the 2nd byte, and no imem_we ever.
REQ-039 The bench SHALL cover: count 00 00 followed by checksum 00 -> DONE with no writes.
REQ-040 The bench SHALL cover: N = 1 with rx_valid deasserted for 5 cycles between bytes -> same single write, with each imem_we pulse exactly 1 cycle long.
REQ-041 The bench SHALL cover: reset asserted after 2 of 4 data bytes, then a full valid stream -> the partial word is never written, and the load completes normally with its word at address 0.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a counted, checksummed byte stream and
// writes it word by word into instruction memory while holding the core in reset.
module prog_loader #(
  parameter int IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_lo_q;
  logic [15:0] n_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] asm_q;
  logic [7:0]  csum_q;
  logic        imem_we_q;
  logic [31:0] imem_addr_q;
  logic [31:0] imem_wdata_q;
  logic        core_reset_q;
  logic        load_done_q;
  logic        load_error_q;

  logic        accept;
  logic [15:0] n_d;
  logic [31:0] word_d;
  logic [7:0]  csum_d;

  // rx_ready is gated by reset directly so no byte can slip in during reset.
  assign rx_ready = !reset && (state_q == CNT_LO || state_q == CNT_HI ||
                               state_q == DATA   || state_q == CSUM);
  assign accept   = rx_valid && rx_ready;

  always_comb begin
    n_d    = {rx_data, cnt_lo_q};
    word_d = {rx_data, asm_q};
    csum_d = csum_q + rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CNT_LO;
      cnt_lo_q     <= 8'd0;
      n_q          <= 16'd0;
      word_idx_q   <= 16'd0;
      byte_cnt_q   <= 2'd0;
      asm_q        <= 24'd0;
      csum_q       <= 8'd0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 32'd0;
      imem_wdata_q <= 32'd0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        CNT_LO: begin
          if (accept) begin
            cnt_lo_q <= rx_data;
            state_q  <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (accept) begin
            n_q <= n_d;
            if ({16'd0, n_d} > 32'(IMEM_WORDS)) begin
              state_q      <= ERROR;
              load_error_q <= 1'b1;
            end else if (n_d == 16'd0) begin
              state_q <= CSUM;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            // Shift right so the first byte ends up in bits [7:0].
            asm_q      <= word_d[31:8];
            if (byte_cnt_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= {14'd0, word_idx_q, 2'b00};
              imem_wdata_q <= word_d;
              word_idx_q   <= word_idx_q + 16'd1;
              if (word_idx_q == n_q - 16'd1) begin
                state_q <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (accept) begin
            if (rx_data == csum_q) begin
              state_q      <= DONE;
              load_done_q  <= 1'b1;
              core_reset_q <= 1'b0;
            end else begin
              state_q      <= ERROR;
              load_error_q <= 1'b1;
            end
          end
        end
        DONE: begin
        end
        ERROR: begin
        end
        default: begin
          state_q      <= ERROR;
          load_error_q <= 1'b1;
        end
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: feeds hand-built program streams and checks
// the memory writes and final status against hand-computed values.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        load_done;
  logic        load_error;

  int compared = 0;
  int failed   = 0;

  logic [31:0] wr_addr [0:2047];
  logic [31:0] wr_data [0:2047];
  int          wr_count = 0;
  int          dbl_pulse = 0;
  logic        prev_we = 1'b0;

  prog_loader #(.IMEM_WORDS(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_reset(core_reset),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle; also flags any strobe longer than one cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_count < 2048) begin
        wr_addr[wr_count] = imem_addr;
        wr_data[wr_count] = imem_wdata;
      end
      wr_count++;
    end
    if (imem_we && prev_we) dbl_pulse++;
    prev_we = imem_we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int i = 0;
    while (!rx_ready && i < 20) begin
      tick();
      i++;
    end
    if (!rx_ready) begin
      chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      return;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int base;

  initial begin
    tick();
    // Reset state, observed while reset is still high.
    tick();
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_load_error", {31'd0, load_error}, 32'd0);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    reset = 1'b0;
    tick();
    chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

    // Two-word image with good checksum.
    base = wr_count;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    chk("ok_pre_csum_core_reset", {31'd0, core_reset}, 32'd1);
    chk("ok_pre_csum_done", {31'd0, load_done}, 32'd0);
    chk("ok_wr_count", wr_count - base, 32'd2);
    chk("ok_wr0_addr", wr_addr[base], 32'h0000_0000);
    chk("ok_wr0_data", wr_data[base], 32'h0000_0013);
    chk("ok_wr1_addr", wr_addr[base+1], 32'h0000_0004);
    chk("ok_wr1_data", wr_data[base+1], 32'h0010_0093);
    send_byte(8'hB6);
    chk("ok_load_done", {31'd0, load_done}, 32'd1);
    chk("ok_core_reset", {31'd0, core_reset}, 32'd0);
    chk("ok_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("ok_load_error", {31'd0, load_error}, 32'd0);

    // Reset from DONE must re-assert core_reset after the next edge.
    reset = 1'b1;
    tick();
    chk("done_rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("done_rst_load_done", {31'd0, load_done}, 32'd0);
    reset = 1'b0;
    tick();

    // Same image, wrong checksum.
    base = wr_count;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'hB7);
    chk("bad_wr_count", wr_count - base, 32'd2);
    chk("bad_wr1_data", wr_data[base+1], 32'h0010_0093);
    chk("bad_load_error", {31'd0, load_error}, 32'd1);
    chk("bad_core_reset", {31'd0, core_reset}, 32'd1);
    chk("bad_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("bad_load_done", {31'd0, load_done}, 32'd0);
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) tick();
    rx_valid = 1'b0;
    chk("bad_sticky_error", {31'd0, load_error}, 32'd1);

    // Oversized count: 257 words.
    apply_reset();
    base = wr_count;
    send_byte(8'h01); send_byte(8'h01);
    chk("big_load_error", {31'd0, load_error}, 32'd1);
    chk("big_rx_ready", {31'd0, rx_ready}, 32'd0);
    repeat (5) tick();
    chk("big_no_writes", wr_count - base, 32'd0);

    // Empty image.
    apply_reset();
    base = wr_count;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("empty_load_done", {31'd0, load_done}, 32'd1);
    chk("empty_core_reset", {31'd0, core_reset}, 32'd0);
    chk("empty_no_writes", wr_count - base, 32'd0);

    // Single word with 5-cycle gaps between bytes; sum DE+AD+BE+EF = 0x338.
    apply_reset();
    base = wr_count;
    send_byte(8'h01); repeat (5) tick();
    send_byte(8'h00); repeat (5) tick();
    send_byte(8'hDE); repeat (5) tick();
    send_byte(8'hAD); repeat (5) tick();
    chk("gap_stalled_ready", {31'd0, rx_ready}, 32'd1);
    chk("gap_stalled_no_wr", wr_count - base, 32'd0);
    send_byte(8'hBE); repeat (5) tick();
    send_byte(8'hEF); repeat (5) tick();
    chk("gap_wr_count", wr_count - base, 32'd1);
    chk("gap_wr0_addr", wr_addr[base], 32'h0000_0000);
    chk("gap_wr0_data", wr_data[base], 32'hEFBE_ADDE);
    chk("gap_pre_done", {31'd0, load_done}, 32'd0);
    send_byte(8'h38);
    chk("gap_load_done", {31'd0, load_done}, 32'd1);

    // Reset after two data bytes, then a clean one-word load.
    apply_reset();
    base = wr_count;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    apply_reset();
    chk("mid_rst_no_wr", wr_count - base, 32'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    send_byte(8'hAA);
    chk("mid_wr_count", wr_count - base, 32'd1);
    chk("mid_wr0_addr", wr_addr[base], 32'h0000_0000);
    chk("mid_wr0_data", wr_data[base], 32'h1122_3344);
    chk("mid_load_done", {31'd0, load_done}, 32'd1);

    // Full memory: 256 words of bytes 0..1023 mod 256, whose sum is 0 mod 256.
    apply_reset();
    base = wr_count;
    send_byte(8'h00); send_byte(8'h01);
    for (int i = 0; i < 1024; i++) send_byte(8'(i));
    send_byte(8'h00);
    chk("full_wr_count", wr_count - base, 32'd256);
    chk("full_last_addr", wr_addr[base+255], 32'h0000_03FC);
    chk("full_last_data", wr_data[base+255], 32'hFFFE_FDFC);
    chk("full_mid_data", wr_data[base+64], 32'h0302_0100);
    chk("full_load_done", {31'd0, load_done}, 32'd1);
    chk("full_load_error", {31'd0, load_error}, 32'd0);

    chk("we_single_cycle", dbl_pulse, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
